// File: rtl/fm_radio_pkg.sv
// Shared constants for the FM tuner I2C path: power-up init table, default
// device address and the configuration sequencer state encoding.
package fm_radio_pkg;

    localparam int N_INIT = 3;
    localparam int IDX_W  = (N_INIT > 1) ? $clog2(N_INIT) : 1;

    localparam logic [15:0] INIT_TABLE [N_INIT] = '{16'hC003, 16'hC00D, 16'h0000};

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INIT_REQ  = 3'd1,
        ST_XFER_WAIT = 3'd2,
        ST_GAP       = 3'd3,
        ST_READY     = 3'd4,
        ST_CMD_REQ   = 3'd5,
        ST_ERROR     = 3'd6
    } seq_state_t;

    // Table lookup written as a compare loop so a non-power-of-two table
    // never sees an out-of-range index.
    function automatic logic [15:0] init_word(input logic [IDX_W-1:0] idx);
        logic [15:0] w_word;
        w_word = '0;
        for (int i = 0; i < N_INIT; i++) begin
            if (idx == IDX_W'(i)) begin
                w_word = INIT_TABLE[i];
            end
        end
        return w_word;
    endfunction

endpackage

// File: rtl/clk_en_gen.sv
// Free-running prescaler: one-cycle registered enable every CLK_DIV clocks.
module clk_en_gen #(
    parameter int CLK_DIV = 125
) (
    input  logic clk,
    input  logic reset_n,
    output logic o_en
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_en;

    always_comb begin
        w_cnt_next = (r_cnt == CNT_W'(CLK_DIV - 1)) ? '0 : r_cnt + 1'b1;
    end

    // Enable is registered off the next count so it is high exactly while
    // the counter sits at CLK_DIV-1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_en  <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            r_en  <= (w_cnt_next == CNT_W'(CLK_DIV - 1));
        end
    end

    assign o_en = r_en;

endmodule

// File: rtl/i2c_config_sequencer.sv
// Drives the write-only I2C controller: plays the tuner init table after start,
// then forwards runtime command words, with an ack timeout.
module i2c_config_sequencer
    import fm_radio_pkg::*;
#(
    parameter int         CLK_DIV  = 125,
    parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT,
    parameter int         INIT_GAP = 16,
    parameter int         TIMEOUT  = 255
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [15:0]     cmd_data,
    output logic            init_done,
    output logic            busy,
    output logic            error,
    output logic            i2c_en,
    output logic [6:0]      i2c_addr,
    output logic [1:0][7:0] i2c_wdata,
    output logic            i2c_req,
    input  logic            i2c_ack
);

    localparam int GAP_W = (INIT_GAP > 1) ? $clog2(INIT_GAP) : 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    seq_state_t       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic             r_tgt_cmd;
    logic             r_req;
    logic [15:0]      r_wdata;
    logic             r_init_done;

    logic w_en;
    logic w_last_word;
    logic w_gap_done;
    logic w_to_last;

    clk_en_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_en_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .o_en    (w_en)
    );

    assign w_last_word = (r_idx == IDX_W'(N_INIT - 1));
    assign w_gap_done  = (INIT_GAP == 0) || (w_en && (r_gap_cnt == GAP_W'(INIT_GAP - 1)));
    assign w_to_last   = (r_to_cnt == TO_W'(TIMEOUT - 1));

    // Ack is a level spanning up to one enable period, so it is only looked
    // at on enable cycles; req drops on the first enable it was seen high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_gap_cnt   <= '0;
            r_to_cnt    <= '0;
            r_tgt_cmd   <= 1'b0;
            r_req       <= 1'b0;
            r_wdata     <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_ERROR: begin
                    if (start) begin
                        r_state     <= ST_INIT_REQ;
                        r_idx       <= '0;
                        r_init_done <= 1'b0;
                        r_wdata     <= init_word('0);
                        r_req       <= 1'b1;
                    end
                end
                ST_INIT_REQ, ST_CMD_REQ: begin
                    if (w_en) begin
                        r_req     <= 1'b0;
                        r_to_cnt  <= '0;
                        r_tgt_cmd <= (r_state == ST_CMD_REQ);
                        r_state   <= ST_XFER_WAIT;
                    end
                end
                ST_XFER_WAIT: begin
                    if (w_en) begin
                        if (i2c_ack) begin
                            r_gap_cnt <= '0;
                            r_state   <= r_tgt_cmd ? ST_READY : ST_GAP;
                        end else if (w_to_last) begin
                            r_init_done <= 1'b0;
                            r_state     <= ST_ERROR;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (w_gap_done) begin
                        if (w_last_word) begin
                            r_init_done <= 1'b1;
                            r_state     <= ST_READY;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_wdata <= init_word(r_idx + 1'b1);
                            r_req   <= 1'b1;
                            r_state <= ST_INIT_REQ;
                        end
                    end else if (w_en) begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                ST_READY: begin
                    if (cmd_valid) begin
                        r_wdata <= cmd_data;
                        r_req   <= 1'b1;
                        r_state <= ST_CMD_REQ;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (r_state == ST_READY);
    assign busy      = (r_state != ST_IDLE) && (r_state != ST_READY) && (r_state != ST_ERROR);
    assign error     = (r_state == ST_ERROR);
    assign init_done = r_init_done;
    assign i2c_en    = w_en;
    assign i2c_addr  = DEV_ADDR;
    assign i2c_wdata = r_wdata;
    assign i2c_req   = r_req;

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// Bench for i2c_config_sequencer with a behavioural I2C controller model and
// a word-level scoreboard on the words the controller latches.
module tb_i2c_config_sequencer;

    localparam int CLK_DIV  = 4;
    localparam int INIT_GAP = 2;
    localparam int TIMEOUT  = 200;
    localparam int LIMIT    = 3000;

    logic            clk;
    logic            reset_n;
    logic            start;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [15:0]     cmd_data;
    logic            init_done;
    logic            busy;
    logic            error;
    logic            i2c_en;
    logic [6:0]      i2c_addr;
    logic [1:0][7:0] i2c_wdata;
    logic            i2c_req;
    logic            i2c_ack;

    i2c_config_sequencer #(
        .CLK_DIV  (CLK_DIV),
        .DEV_ADDR (7'h10),
        .INIT_GAP (INIT_GAP),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .init_done (init_done),
        .busy      (busy),
        .error     (error),
        .i2c_en    (i2c_en),
        .i2c_addr  (i2c_addr),
        .i2c_wdata (i2c_wdata),
        .i2c_req   (i2c_req),
        .i2c_ack   (i2c_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] cmd;
        logic [7:0]  exp_first;
        logic [7:0]  exp_second;
        int          pre_idle;
    } cmd_vec_t;

    int          checks;
    int          errors;
    logic [15:0] exp_q[$];
    int          exp_total;

    // controller model state
    int          m_state;     // 0 idle, 1 busy, 2 acking
    int          m_cnt;
    logic [15:0] m_word;
    logic        ack_enable;
    int          en_total;
    int          req_en_cnt;
    int          xfer_seen;
    int          last_ack_en;
    int          acc_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One enable-qualified step of the controller model, evaluated mid-cycle.
    task automatic model_step();
        int          prev;
        logic [15:0] exp_w;
        if (!reset_n) begin
            m_state = 0;
            m_cnt   = 0;
            i2c_ack = 1'b0;
        end else if (i2c_en) begin
            en_total++;
            prev = m_state;
            if (i2c_req) req_en_cnt++;
            if (m_state == 1) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    if (ack_enable) begin
                        i2c_ack     = 1'b1;
                        m_state     = 2;
                        last_ack_en = en_total;
                        check("wdata_hold", 32'(i2c_wdata), 32'(m_word));
                    end else begin
                        m_state = 0;
                    end
                end
            end else if (m_state == 2) begin
                i2c_ack = 1'b0;
                m_state = 0;
            end
            if (i2c_req && prev == 1) begin
                check("req_while_ctrl_busy", 32'(i2c_req), 32'd0);
            end else if (i2c_req && m_state == 0) begin
                m_word = i2c_wdata;
                acc_en = en_total;
                m_cnt  = 3;
                m_state = 1;
                xfer_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(m_word), 32'hFFFF_FFFF);
                end else begin
                    exp_w = exp_q.pop_front();
                    check("bus_write", {9'd0, i2c_addr, m_word}, {9'd0, 7'h10, exp_w});
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
    endtask

    task automatic push_init();
        exp_q.push_back(16'hC003);
        exp_q.push_back(16'hC00D);
        exp_q.push_back(16'h0000);
        exp_total += 3;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        exp_total -= exp_q.size();
        exp_q.delete();
    endtask

    task automatic wait_init_done(input string name);
        for (int i = 0; i < LIMIT && !init_done; i++) tick();
        check(name, 32'(init_done), 32'd1);
    endtask

    task automatic wait_cmd_ready(input string name);
        for (int i = 0; i < LIMIT && !cmd_ready; i++) tick();
        check(name, 32'(cmd_ready), 32'd1);
    endtask

    cmd_vec_t vecs [4];

    initial begin
        int early_ready;
        int base;

        vecs[0] = '{cmd: 16'hA55A, exp_first: 8'hA5, exp_second: 8'h5A, pre_idle: 0};
        vecs[1] = '{cmd: 16'h00FF, exp_first: 8'h00, exp_second: 8'hFF, pre_idle: 1};
        vecs[2] = '{cmd: 16'hFF00, exp_first: 8'hFF, exp_second: 8'h00, pre_idle: 2};
        vecs[3] = '{cmd: 16'h8001, exp_first: 8'h80, exp_second: 8'h01, pre_idle: 3};

        checks = 0; errors = 0; exp_total = 0;
        m_state = 0; m_cnt = 0; m_word = '0; ack_enable = 1'b1;
        en_total = 0; req_en_cnt = 0; xfer_seen = 0; last_ack_en = 0; acc_en = 0;
        i2c_ack = 1'b0; reset_n = 1'b0; start = 1'b0; cmd_valid = 1'b0; cmd_data = '0;

        // reset values
        repeat (3) tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_req", 32'(i2c_req), 32'd0);
        check("rst_en", 32'(i2c_en), 32'd0);
        check("rst_wdata", 32'(i2c_wdata), 32'd0);
        reset_n = 1'b1;
        tick();
        check("addr", 32'(i2c_addr), 32'h10);

        // start and a held command together in IDLE: start wins, command waits
        start = 1'b1; cmd_valid = 1'b1; cmd_data = 16'h1234;
        check("start_cmd_ready_idle", 32'(cmd_ready), 32'd0);
        push_init();
        tick();
        start = 1'b0;
        check("start_busy", 32'(busy), 32'd1);
        check("start_req", 32'(i2c_req), 32'd1);
        check("start_word0", 32'(i2c_wdata), 32'hC003);
        early_ready = 0;
        for (int i = 0; i < LIMIT && !init_done; i++) begin
            tick();
            if (cmd_ready && !init_done) early_ready++;
        end
        check("init_done", 32'(init_done), 32'd1);
        check("ready_during_init", 32'(early_ready), 32'd0);
        check("init_gap_ticks", 32'(en_total - last_ack_en), 32'd2);
        check("ready_at_done", 32'(cmd_ready), 32'd1);
        check("idle_after_init", 32'(busy), 32'd0);
        check("init_words_seen", 32'(exp_q.size()), 32'd0);
        exp_q.push_back(16'h1234);
        exp_total++;
        tick();
        cmd_valid = 1'b0;
        check("cmd_taken", 32'(cmd_ready), 32'd0);
        check("cmd_wdata", 32'(i2c_wdata), 32'h1234);
        wait_cmd_ready("cmd_back_ready");
        check("cmd_word_seen", 32'(exp_q.size()), 32'd0);

        // table of runtime commands at varying enable phases
        foreach (vecs[k]) begin
            for (int d = 0; d < vecs[k].pre_idle; d++) tick();
            wait_cmd_ready("vec_ready_in");
            cmd_valid = 1'b1;
            cmd_data  = vecs[k].cmd;
            exp_q.push_back({vecs[k].exp_first, vecs[k].exp_second});
            exp_total++;
            tick();
            cmd_valid = 1'b0;
            check("vec_accept", 32'(cmd_ready), 32'd0);
            wait_cmd_ready("vec_ready_out");
            check("vec_word_seen", 32'(exp_q.size()), 32'd0);
            check("vec_init_done", 32'(init_done), 32'd1);
        end

        // start in READY is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("start_ready_busy", 32'(busy), 32'd0);
        check("start_ready_ready", 32'(cmd_ready), 32'd1);
        check("start_ready_done", 32'(init_done), 32'd1);

        // stalled controller: timeout, then recovery by a second start
        pulse_reset();
        ack_enable = 1'b0;
        start = 1'b1;
        exp_q.push_back(16'hC003);
        exp_total++;
        tick();
        start = 1'b0;
        for (int i = 0; i < LIMIT && !error; i++) tick();
        check("timeout_error", 32'(error), 32'd1);
        check("timeout_ticks", 32'(en_total - acc_en), 32'(TIMEOUT));
        check("timeout_req", 32'(i2c_req), 32'd0);
        check("timeout_init_done", 32'(init_done), 32'd0);
        check("timeout_busy", 32'(busy), 32'd0);
        ack_enable = 1'b1;
        start = 1'b1;
        push_init();
        tick();
        start = 1'b0;
        check("error_cleared", 32'(error), 32'd0);
        wait_init_done("recover_init_done");
        check("recover_error", 32'(error), 32'd0);
        check("recover_words", 32'(exp_q.size()), 32'd0);

        // asynchronous reset in the middle of word 2
        pulse_reset();
        start = 1'b1;
        push_init();
        tick();
        start = 1'b0;
        base = xfer_seen;
        for (int i = 0; i < LIMIT && xfer_seen < base + 1; i++) tick();
        check("word2_started", 32'(xfer_seen - base), 32'd1);
        for (int i = 0; i < LIMIT && xfer_seen < base + 2; i++) tick();
        check("word2_reached", 32'(xfer_seen - base), 32'd2);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_cmd_ready", 32'(cmd_ready), 32'd0);
        check("async_init_done", 32'(init_done), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_error", 32'(error), 32'd0);
        check("async_req", 32'(i2c_req), 32'd0);
        check("async_en", 32'(i2c_en), 32'd0);
        check("async_wdata", 32'(i2c_wdata), 32'd0);
        exp_total -= exp_q.size();
        exp_q.delete();
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        start = 1'b1;
        push_init();
        tick();
        start = 1'b0;
        check("restart_word0", 32'(i2c_wdata), 32'hC003);
        wait_init_done("restart_init_done");
        check("restart_words", 32'(exp_q.size()), 32'd0);

        // exactly one enable-qualified request per word over the whole run
        check("req_per_word", 32'(req_en_cnt), 32'(exp_total));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_config_sequencer.md
Name: i2c_config_sequencer

Overview:
- Sequences the write-only I2C controller for the FM radio tuner.
- After `start`, writes a fixed init table of 16-bit words to device `DEV_ADDR`, then accepts runtime 16-bit command words (tune/volume/mute) one at a time.
- Generates the controller's clock-enable strobe, runs the req/ack handshake, and times out a stalled transfer.
- Sits between the top-level UI/control logic and `i2c_controller`.

Parameters:
- `CLK_DIV`, 125, clk cycles per `i2c_en` pulse (4x SCL bit rate; 50 MHz -> 100 kHz SCL); legal range >= 2.
- `DEV_ADDR`, 7'h10, 7-bit I2C device address driven on `i2c_addr`.
- `INIT_GAP`, 16, idle `i2c_en` ticks inserted after each init-table write.
- `TIMEOUT`, 255, max `i2c_en` ticks from req acceptance to ack before error.

Ports:
- `clk`  in  1  clock
- `reset_n`  in  1  asynchronous active-low reset
- `start`  in  1  one-cycle pulse: run init table (ignored unless in IDLE or ERROR)
- `cmd_valid`  in  1  command word valid
- `cmd_ready`  out  1  command accepted this cycle (`cmd_valid && cmd_ready` = transfer)
- `cmd_data`  in  16  command word, [15:8] first byte on the bus
- `init_done`  out  1  init table completed; held until next start/reset/error
- `busy`  out  1  any transfer or gap in progress
- `error`  out  1  sticky timeout flag; cleared by start or reset
- `i2c_en`  out  1  one-cycle strobe every `CLK_DIV` clks
- `i2c_addr`  out  7  constant `DEV_ADDR`
- `i2c_wdata`  out  2x8  {first byte, second byte}; held stable from req until ack
- `i2c_req`  out  1  transfer request
- `i2c_ack`  in  1  controller acknowledge (level, valid on `i2c_en` cycles)

Behaviour:
- Reset values: `cmd_ready`, `init_done`, `busy`, `error`, `i2c_req`, `i2c_en` = 0; `i2c_wdata` = 0; state IDLE; all counters 0.
- Prescaler:
  - Free-running counter 0..`CLK_DIV`-1.
  - `i2c_en` = 1 in the cycle the counter equals `CLK_DIV`-1. Registered output.
- Handshake rules:
  - `i2c_ack` is sampled only on cycles with `i2c_en`=1. `ack` is a level lasting up to one `en` period, so an unqualified sample would double-count it.
  - `i2c_req` is raised with `i2c_wdata` valid and dropped in the first `i2c_en` cycle in which it was high; the controller has latched it then. Req must not be high when the controller returns to idle, or it re-sends.
  - Exactly one `i2c_req` `en`-acceptance per word.
- FSM states:
  - IDLE: `start` -> INIT_REQ with `idx`=0, `error`=0, `init_done`=0.
  - INIT_REQ: `i2c_wdata`=`INIT_TABLE[idx]`, `i2c_req`=1; on `i2c_en` -> XFER_WAIT (return target = INIT).
  - XFER_WAIT:
    - On `i2c_en` with ack: INIT target -> GAP; CMD target -> READY.
    - Timeout counter counts `i2c_en` ticks; reaching `TIMEOUT` without ack -> ERROR.
  - GAP:
    - Counts `INIT_GAP` `i2c_en` ticks (`INIT_GAP`=0 -> skip).
    - Then if `idx`==`N_INIT`-1 -> READY with `init_done`=1, else `idx`+1 -> INIT_REQ.
  - READY:
    - `cmd_ready`=1 (combinational from state); on `cmd_valid` latch `cmd_data` -> CMD_REQ.
    - `start` in READY is ignored.
  - CMD_REQ: as INIT_REQ with the latched command; -> XFER_WAIT (target CMD).
  - ERROR: `error`=1, `i2c_req`=0; `start` -> INIT_REQ (clears `error`, `init_done`).
- `busy` = state not in {IDLE, READY, ERROR}.
- `cmd_valid` outside READY: not accepted, word held by the source (valid/ready rule); no drop, no queue.
- Simultaneous `start` and `cmd_valid` in IDLE/ERROR: `start` wins; `cmd_ready`=0.
- Reset mid-transfer: immediate return to reset values. The controller is reset on the same net, so no bus fix-up is required here.
- Counter widths:
  - `$clog2` of their limits; `idx` width `$clog2(N_INIT)`; `N_INIT` >= 1.
  - No counter wraps in normal flow; timeout counter saturates.

Decomposition:
- Package `fm_radio_pkg`:
  - `N_INIT`, `INIT_TABLE` (array of 16-bit words, tuner power-up/config values).
  - FSM state enum type.
  - Default `DEV_ADDR`.
- One sub-module, `clk_en_gen`: prescaler producing `i2c_en`, parameter `CLK_DIV`, reusable elsewhere.

Test Plan:
- Bench setup: `CLK_DIV`=4, `INIT_GAP`=2, `TIMEOUT`=200, `N_INIT`=3 with table {16'hC003, 16'hC00D, 16'h0000}, `i2c_controller` model attached and bus monitor on SCL/SDA.
- Reset + `start` -> 3 bus writes in order C0 03, C0 0D, 00 00 to addr 7'h10. `init_done` rises after third ack + 2 en ticks; `busy` 0 afterwards.
- Request count: count `i2c_en` cycles with `i2c_req`=1 -> exactly 1 per word. No repeated bus transaction while ack level persists.
- `cmd_valid` with 16'h1234 held during init -> `cmd_ready` stays 0 until `init_done`. Then accepted in 1 cycle, bus write 12 34, return to READY.
- Ack tied 0 after start -> `error`=1 after 200 `en` ticks, `i2c_req`=0, `init_done`=0. Second `start` with working ack -> `error` clears, full init completes.
- `reset_n` low mid-way through word 2 -> all outputs 0 within the same cycle (async). Next `start` -> sequence restarts from word 0.
- `start` and `cmd_valid` asserted together in IDLE -> init begins, no command accepted.
